// File: rtl/led_panel_scan.sv
// led_panel_scan: scans a two-half RGB LED panel row by row and steps the PWM threshold once per frame.
// Optional feature: define BLANK_EXT_EN to keep the panel blanked for the whole latch window.
module led_panel_scan #(
  parameter int PIXELS_PER_ROW = 64,
  parameter int ROWS = 16,
  parameter int PWM_MAX = 254
) (
  input  logic       in_clk,
  input  logic       in_nrst,
  input  logic       led_clk,
  input  logic       pwm_cntr_strobe,
  input  logic       alrst_strobe,
  input  logic [2:0] rgb1,
  input  logic [2:0] rgb2,
  output logic [7:0] pwm_value,
  output logic [2:0] panel_rgb1,
  output logic [2:0] panel_rgb2,
  output logic       panel_clk,
  output logic       panel_lat,
  output logic       panel_oe_n,
  output logic [3:0] row_addr,
  output logic       al_rrst_n,
  output logic       frame_sync
);
  localparam int PW = $clog2(PIXELS_PER_ROW);
  typedef enum logic [1:0] {F_IDLE, F_WAIT_PWM, F_WAIT_RST} fstate_t;
  fstate_t r_fst;
  logic [2:0] r_sub;
  logic [PW-1:0] r_pix;
  logic [3:0] r_srow;
  logic r_lpend, r_lwin, r_oe_en;
  logic [2:0] r_rgb1, r_rgb2;
  logic r_clk, r_lat, r_oe_n, r_fs, r_arn;
  logic [3:0] r_row;
  logic [7:0] r_pwm;
  logic [2:0] w_sub;
  logic w_lwin, w_start, w_oe_en, w_blank, w_fset, w_pix_last, w_srow_last;
  assign w_sub       = led_clk ? 3'd0 : (r_sub == 3'd5 ? 3'd5 : r_sub + 3'd1);
  assign w_lwin      = led_clk ? r_lpend : r_lwin;
  assign w_start     = led_clk & r_lpend;
  assign w_oe_en     = r_oe_en | (r_lwin & (r_sub == 3'd1));
  assign w_pix_last  = r_pix == PW'(PIXELS_PER_ROW - 1);
  assign w_srow_last = r_srow == 4'(ROWS - 1);
  assign w_fset      = w_start & w_srow_last;
`ifdef BLANK_EXT_EN
  assign w_blank = w_lwin;
`else
  assign w_blank = w_lwin & (w_sub <= 3'd1);
`endif
  // pixel timing: sub-phase, pixel/row counters and latch-window tracking
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      r_sub   <= 3'd5;
      r_pix   <= '0;
      r_lpend <= 1'b0;
      r_lwin  <= 1'b0;
      r_oe_en <= 1'b0;
      r_srow  <= '0;
    end else begin
      r_sub   <= w_sub;
      r_lwin  <= w_lwin;
      r_oe_en <= w_oe_en;
      if (led_clk) begin
        r_pix   <= w_pix_last ? '0 : r_pix + PW'(1);
        r_lpend <= w_pix_last;
        if (r_lpend) r_srow <= w_srow_last ? '0 : r_srow + 4'd1;
      end
    end
  end
  // panel-side outputs, registered from next-state values so they align with the sub-phase
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      r_rgb1 <= '0;
      r_rgb2 <= '0;
      r_clk  <= 1'b0;
      r_lat  <= 1'b0;
      r_oe_n <= 1'b1;
      r_row  <= '0;
    end else begin
      if (led_clk) begin
        r_rgb1 <= rgb1;
        r_rgb2 <= rgb2;
      end
      if (w_start) r_row <= r_srow;
      r_clk  <= (w_sub >= 3'd2) & (w_sub <= 3'd4);
      r_lat  <= w_lwin & (w_sub <= 3'd1);
      r_oe_n <= ~w_oe_en | w_blank;
    end
  end
  // frame handshake: frame end -> PWM step on its strobe -> FIFO read reset on its strobe
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      r_fst <= F_IDLE;
      r_pwm <= '0;
      r_fs  <= 1'b0;
      r_arn <= 1'b1;
    end else begin
      r_fs  <= 1'b0;
      r_arn <= 1'b1;
      case (r_fst)
        F_IDLE:
          if (w_fset) r_fst <= F_WAIT_PWM;
        F_WAIT_PWM:
          if (pwm_cntr_strobe) begin
            r_fst <= F_WAIT_RST;
            r_pwm <= r_pwm == 8'(PWM_MAX) ? 8'd0 : r_pwm + 8'd1;
            r_fs  <= 1'b1;
          end
        F_WAIT_RST:
          if (alrst_strobe) begin
            r_fst <= F_IDLE;
            r_arn <= 1'b0;
          end
        default: r_fst <= F_IDLE;
      endcase
    end
  end
  assign pwm_value  = r_pwm;
  assign panel_rgb1 = r_rgb1;
  assign panel_rgb2 = r_rgb2;
  assign panel_clk  = r_clk;
  assign panel_lat  = r_lat;
  assign panel_oe_n = r_oe_n;
  assign row_addr   = r_row;
  assign al_rrst_n  = r_arn;
  assign frame_sync = r_fs;
endmodule

// File: tb/tb_led_panel_scan.sv
// tb_led_panel_scan: table vectors, hand sequences and a random run against a count-based reference model.
module tb_led_panel_scan;
  localparam int P = 4, R = 3, PM = 254;
  logic in_clk = 0, in_nrst = 0, led_clk = 0, pwm_cntr_strobe = 0, alrst_strobe = 0;
  logic [2:0] rgb1 = 0, rgb2 = 0;
  logic [7:0] pwm_value;
  logic [2:0] panel_rgb1, panel_rgb2;
  logic panel_clk, panel_lat, panel_oe_n, al_rrst_n, frame_sync;
  logic [3:0] row_addr;
  int total = 0, bad = 0;
  int m_n, m_k, m_pwm, m_row;
  bit m_win, m_done, m_pend, m_adv, m_fs, m_ar;
  logic [2:0] m_r1, m_r2;
  logic [7:0] last_pwm = 0;
  bit wrapped = 0;
  typedef struct {
    logic [2:0] a, b;
    logic [5:0] ck, lt, oe;
    logic [3:0] row;
  } vec_t;
  vec_t tbl[6];

  always #5 in_clk = ~in_clk;

  led_panel_scan #(.PIXELS_PER_ROW(P), .ROWS(R), .PWM_MAX(PM)) dut (
    .in_clk(in_clk), .in_nrst(in_nrst), .led_clk(led_clk),
    .pwm_cntr_strobe(pwm_cntr_strobe), .alrst_strobe(alrst_strobe),
    .rgb1(rgb1), .rgb2(rgb2), .pwm_value(pwm_value),
    .panel_rgb1(panel_rgb1), .panel_rgb2(panel_rgb2), .panel_clk(panel_clk),
    .panel_lat(panel_lat), .panel_oe_n(panel_oe_n), .row_addr(row_addr),
    .al_rrst_n(al_rrst_n), .frame_sync(frame_sync)
  );

  always @(negedge in_clk) begin
    if (in_nrst && last_pwm == 8'd254 && pwm_value == 8'd0) wrapped = 1;
    last_pwm = pwm_value;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_k = 5; m_pwm = 0; m_row = 0;
    m_win = 0; m_done = 0; m_pend = 0; m_adv = 0; m_fs = 0; m_ar = 1;
    m_r1 = 0; m_r2 = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pwm"}, pwm_value, 0);
    chk({tag, "_rgb"}, {panel_rgb1, panel_rgb2}, 0);
    chk({tag, "_clk"}, panel_clk, 0);
    chk({tag, "_lat"}, panel_lat, 0);
    chk({tag, "_oe_n"}, panel_oe_n, 1);
    chk({tag, "_row"}, row_addr, 0);
    chk({tag, "_al_rrst_n"}, al_rrst_n, 1);
    chk({tag, "_frame_sync"}, frame_sync, 0);
  endtask

  task automatic cycle(input bit lc, input bit ps, input bit as, input logic [2:0] a, input logic [2:0] b);
    bit p0, a0, lat;
    led_clk = lc; pwm_cntr_strobe = ps; alrst_strobe = as; rgb1 = a; rgb2 = b;
    @(posedge in_clk);
    p0 = m_pend; a0 = m_adv; m_fs = 0; m_ar = 1;
    if (lc) begin
      m_r1 = a; m_r2 = b; m_k = 0;
      m_win = (m_n >= P) && (m_n % P == 0);
      if (m_win) begin
        m_row = (m_n / P - 1) % R;
        if (m_row == R - 1) m_pend = 1;
      end
      m_n++;
    end else if (m_k < 5) m_k++;
    if (ps && p0 && !a0) begin m_pwm = (m_pwm + 1) % (PM + 1); m_adv = 1; m_fs = 1; end
    if (as && p0 && a0) begin m_ar = 0; m_pend = 0; m_adv = 0; end
    if (m_win && m_k >= 2) m_done = 1;
    @(negedge in_clk);
    lat = m_win && m_k <= 1;
    chk("m_rgb1", panel_rgb1, m_r1);
    chk("m_rgb2", panel_rgb2, m_r2);
    chk("m_clk", panel_clk, m_k >= 2 && m_k <= 4);
    chk("m_lat", panel_lat, lat);
`ifdef BLANK_EXT_EN
    chk("m_oe_n", panel_oe_n, !m_done || m_win);
`else
    chk("m_oe_n", panel_oe_n, !m_done || lat);
`endif
    chk("m_row", row_addr, m_row);
    chk("m_pwm", pwm_value, m_pwm);
    chk("m_frame_sync", frame_sync, m_fs);
    chk("m_al_rrst_n", al_rrst_n, m_ar);
  endtask

  task automatic pixels(input int cnt);
    for (int i = 0; i < cnt; i++)
      for (int j = 0; j < 6; j++) cycle(j == 0, 0, 0, 3'($urandom), 3'($urandom));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge in_clk);
    #1 chk_reset_vals("rst");
    @(negedge in_clk);
    in_nrst = 1;
    tbl[0] = '{3'b101, 3'b010, 6'b011100, 6'b000000, 6'b111111, 4'd0};
    tbl[1] = '{3'b011, 3'b100, 6'b011100, 6'b000000, 6'b111111, 4'd0};
    tbl[2] = '{3'b110, 3'b001, 6'b011100, 6'b000000, 6'b111111, 4'd0};
    tbl[3] = '{3'b111, 3'b000, 6'b011100, 6'b000000, 6'b111111, 4'd0};
`ifdef BLANK_EXT_EN
    tbl[4] = '{3'b001, 3'b110, 6'b011100, 6'b000011, 6'b111111, 4'd0};
`else
    tbl[4] = '{3'b001, 3'b110, 6'b011100, 6'b000011, 6'b000011, 4'd0};
`endif
    tbl[5] = '{3'b100, 3'b011, 6'b011100, 6'b000000, 6'b000000, 4'd0};
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 6; k++) begin
        cycle(k == 0, 0, 0, tbl[i].a, tbl[i].b);
        chk("tbl_rgb1", panel_rgb1, tbl[i].a);
        chk("tbl_rgb2", panel_rgb2, tbl[i].b);
        chk("tbl_clk", panel_clk, tbl[i].ck[k]);
        chk("tbl_lat", panel_lat, tbl[i].lt[k]);
        chk("tbl_oe_n", panel_oe_n, tbl[i].oe[k]);
        chk("tbl_row", row_addr, tbl[i].row);
      end
    pixels(P * R + 1 - 6);
    cycle(0, 0, 1, 0, 0);
    chk("early_alrst", al_rrst_n, 1);
    cycle(0, 1, 0, 0, 0);
    chk("adv_pwm", pwm_value, 1);
    chk("adv_fs", frame_sync, 1);
    cycle(0, 1, 0, 0, 0);
    chk("adv_fs_once", frame_sync, 0);
    chk("adv_pwm_hold", pwm_value, 1);
    cycle(0, 0, 1, 0, 0);
    chk("alrst_low", al_rrst_n, 0);
    cycle(0, 0, 1, 0, 0);
    chk("alrst_once", al_rrst_n, 1);
    pixels(2 * P * R);
    cycle(0, 1, 0, 0, 0);
    chk("noqueue_pwm", pwm_value, 2);
    cycle(0, 0, 1, 0, 0);
    chk("noqueue_alrst", al_rrst_n, 0);
    cycle(0, 1, 0, 0, 0);
    chk("noqueue_pwm_hold", pwm_value, 2);
    chk("noqueue_fs", frame_sync, 0);
    for (int c = 0; c < 60000 && !wrapped; ) begin
      int gap = 6 + (($urandom % 8 == 0) ? int'($urandom % 3) : 0);
      for (int j = 0; j < gap; j++)
        cycle(j == 0, $urandom % 10 == 0, $urandom % 10 == 0, 3'($urandom), 3'($urandom));
      c += gap;
    end
    chk("pwm_wrap_254_to_0", wrapped, 1);
    pixels(2 * P + 2);
    #2 in_nrst = 0;
    #1 chk_reset_vals("midrst");
    repeat (2) @(posedge in_clk);
    #1 chk_reset_vals("midrst_hold");
    @(negedge in_clk);
    in_nrst = 1;
    model_reset();
    pixels(2 * P * R + 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_panel_scan.md
LED_PANEL_SCAN -- requirements
Module: led_panel_scan

Interface
REQ-001 Parameter PIXELS_PER_ROW, default 64: panel pixels shifted per row; range 2..256.
REQ-002 Parameter ROWS, default 16: scan rows per frame; range 2..16.
REQ-003 Parameter PWM_MAX, default 254: last pwm_value of a PWM cycle.
REQ-004 in_clk  input  1: system clock; all logic on its rising edge.
REQ-005 in_nrst  input  1: reset, asynchronous, active-low.
REQ-006 led_clk  input  1: one-cycle pixel strobe from the receive stage, nominally every 6th in_clk; rgb1/rgb2 valid while high.
REQ-007 pwm_cntr_strobe  input  1: one-cycle strobe, PWM counter update slot.
REQ-008 alrst_strobe  input  1: one-cycle strobe, FIFO read-reset slot.
REQ-009 rgb1, rgb2  input  3 each: upper/lower half-panel pixel bits {R,G,B}.
REQ-010 pwm_value  output  8: PWM threshold for the receive-stage comparator.
REQ-011 panel_rgb1, panel_rgb2  output  3 each: registered panel data.
REQ-012 panel_clk  output  1: panel shift clock.
REQ-013 panel_lat  output  1: panel latch, active-high.
REQ-014 panel_oe_n  output  1: panel output enable, active-low.
REQ-015 row_addr  output  4: displayed row address.
REQ-016 al_rrst_n  output  1: AL422 read-pointer reset, active-low, one cycle.
REQ-017 frame_sync  output  1: one-cycle pulse, coincident with each PWM advance.

Function
REQ-018 Sub-phase counter sub (0..5) SHALL load 0 on an edge sampling led_clk=1, otherwise increment, saturating at 5.
REQ-019 On an edge sampling led_clk=1, panel_rgb1/panel_rgb2 SHALL load rgb1/rgb2.
REQ-020 panel_clk SHALL be 1 exactly while sub is 2, 3 or 4; a missing led_clk leaves panel_clk low.
REQ-021 Pixel counter (0..PIXELS_PER_ROW-1) SHALL advance on each led_clk edge and wrap; the first led_clk after reset is pixel 0 of row 0.
REQ-022 Capturing pixel PIXELS_PER_ROW-1 SHALL set latch_pending; the next led_clk edge SHALL clear it and start a latch window.
REQ-023 Latch window: panel_lat=1 and panel_oe_n=1 while sub is 0 or 1; row_addr SHALL load the index of the row just shifted at the window's first edge.
REQ-024 Outside blanking, panel_oe_n SHALL be 0; after reset it stays 1 until the first latch window completes.
REQ-025 Shift-row counter (0..ROWS-1) SHALL advance at each latch-window start and wrap to 0 after ROWS-1.
REQ-026 A latch window for row ROWS-1 SHALL set frame_pending.
REQ-027 With frame_pending set, the next pwm_cntr_strobe SHALL increment pwm_value (PWM_MAX wraps to 0) and pulse frame_sync for that cycle.
REQ-028 With frame_pending set and pwm_value already advanced, the next alrst_strobe SHALL drive al_rrst_n=0 for that one cycle and clear frame_pending.
REQ-029 pwm_value SHALL be constant between advances; it never changes mid-frame.
REQ-030 A led_clk coincident with a strobe SHALL be processed normally; the strobes act independently.
REQ-031 A second frame end while frame_pending is still set SHALL NOT queue a second advance.

Reset
REQ-032 In reset: pwm_value=0, panel_rgb1/2=0, panel_clk=0, panel_lat=0, panel_oe_n=1, row_addr=0, al_rrst_n=1, frame_sync=0, sub=5.
REQ-033 In reset: all counters and pending flags are 0.
REQ-034 Reset asserted mid-row or mid-frame SHALL abort at once with no latch or al_rrst_n pulse.

Configuration
REQ-035 With BLANK_EXT_EN defined, panel_oe_n SHALL stay 1 for the whole 6-cycle latch window (sub 0..5) and until the next led_clk.
REQ-036 Without BLANK_EXT_EN, blanking SHALL be limited to sub 0..1 of the latch window.

Verification
REQ-037 Reset released, led_clk every 6th cycle, rgb1=3'b101 -> panel_rgb1=3'b101 one cycle after strobe; panel_clk high 3 cycles per period, rising 2 cycles after the strobe edge.
REQ-038 Drive 64 strobes -> panel_lat high 2 cycles after the 65th strobe edge; row_addr=0; panel_oe_n high those same 2 cycles.
REQ-039 Drive 16x64 pixels + 1 with strobes running -> pwm_value 0->1 and frame_sync on the next pwm_cntr_strobe; al_rrst_n low one cycle on the following alrst_strobe.
REQ-040 Run 255 frames -> pwm_value wraps 254->0; row_addr sequence 0..15 repeats each frame.
REQ-041 Assert in_nrst mid-row 3 -> all outputs at reset values; after release, first strobe restarts row 0 pixel 0.
REQ-042 Compile with BLANK_EXT_EN -> panel_oe_n high 6 cycles per latch window; panel_lat still 2 cycles.
